// File: rtl/spike_pkg.sv
// Shared definitions for the spike-train generator.
// Holds the default channel count and counter width, the per-channel
// state encoding, and the width of the dropped-event counter.
package spike_pkg;

  localparam int N_CH_DFLT  = 8;
  localparam int CNT_W_DFLT = 4;
  localparam int DROP_W     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    REFRACT = 2'd2
  } spk_state_t;

endpackage

// File: rtl/spike_channel.sv
// One spike-train channel: turns a single-cycle event into a spike that
// is high for a latched number of cycles, followed by a latched low
// refractory gap. Events are only taken while idle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   boot_mode       - freeze: every register holds, event ignored
//   event_in        - one-cycle event request
//   high_cycles     - high duration, sampled on acceptance (0 -> 1)
//   refract_cycles  - low gap duration, sampled on acceptance (0 -> 1)
//   spike           - spike output (decoded straight from the state flop)
//   busy            - channel not idle (decoded straight from the state flop)
module spike_channel
  import spike_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_mode,
  input  logic             event_in,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] refract_cycles,
  output logic             spike,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  spk_state_t       state, state_nx;
  logic [CNT_W-1:0] hcnt, hcnt_nx;
  logic [CNT_W-1:0] rcnt, rcnt_nx;

  // A programmed zero still has to produce one visible cycle.
  function automatic logic [CNT_W-1:0] clamp_min1(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
      rcnt  <= rcnt_nx;
    end
  end

  // Both durations are captured at acceptance so that a spike in flight
  // is immune to later changes on the config inputs.
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    rcnt_nx  = rcnt;
    if (!boot_mode) begin
      case (state)
        IDLE: begin
          if (event_in) begin
            state_nx = HIGH;
            hcnt_nx  = clamp_min1(high_cycles);
            rcnt_nx  = clamp_min1(refract_cycles);
          end
        end
        HIGH: begin
          if (hcnt == ONE) state_nx = REFRACT;
          else             hcnt_nx  = hcnt - ONE;
        end
        REFRACT: begin
          if (rcnt == ONE) state_nx = IDLE;
          else             rcnt_nx  = rcnt - ONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign spike = (state == HIGH);
  assign busy  = (state != IDLE);

endmodule

// File: rtl/spike_train_gen.sv
// Per-channel spike-train generator for the SNN input-layer spike bus.
// Each accepted event yields a registered spike of programmable width
// followed by a guaranteed low gap, so a downstream posedge detector
// recovers exactly one edge per accepted event.
// Optional feature macro: SPIKE_DROP_CNT_EN adds drop_count, a saturating
// count of events that arrived while their channel was not idle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   boot_mode       - freeze all state; events ignored and not counted
//   event_in        - per-channel one-cycle event requests
//   high_cycles     - spike high duration (0 treated as 1)
//   refract_cycles  - post-spike low duration (0 treated as 1)
//   spike_out       - registered spike train
//   busy            - registered per-channel not-idle flag
//   drop_count      - saturating dropped-event counter (macro only)
module spike_train_gen
  import spike_pkg::*;
#(
  parameter int N_CH  = N_CH_DFLT,
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_mode,
  input  logic [N_CH-1:0]   event_in,
  input  logic [CNT_W-1:0]  high_cycles,
  input  logic [CNT_W-1:0]  refract_cycles,
  output logic [N_CH-1:0]   spike_out,
  output logic [N_CH-1:0]   busy
`ifdef SPIKE_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_count
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    spike_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .boot_mode     (boot_mode),
      .event_in      (event_in[i]),
      .high_cycles   (high_cycles),
      .refract_cycles(refract_cycles),
      .spike         (spike_out[i]),
      .busy          (busy[i])
    );
  end

`ifdef SPIKE_DROP_CNT_EN
  localparam logic [DROP_W:0] DROP_MAX = {1'b0, {DROP_W{1'b1}}};

  logic [DROP_W-1:0] drop_q;

  function automatic logic [DROP_W:0] popcount(input logic [N_CH-1:0] v);
    logic [DROP_W:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + {{DROP_W{1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] acc,
                                                input logic [DROP_W:0]   inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, acc} + inc;
    return (sum > DROP_MAX) ? DROP_MAX[DROP_W-1:0] : sum[DROP_W-1:0];
  endfunction

  // busy is the registered not-idle flag, i.e. exactly the condition under
  // which a channel will refuse this cycle's event.
  always_ff @(posedge clk) begin
    if (rst)             drop_q <= '0;
    else if (!boot_mode) drop_q <= sat_add(drop_q, popcount(event_in & busy));
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_spike_train_gen.sv
module tb_spike_train_gen;

  logic       clk;
  logic       rst;
  logic       boot_mode;
  logic [7:0] event_in;
  logic [3:0] high_cycles;
  logic [3:0] refract_cycles;
  logic [7:0] spike_out;
  logic [7:0] busy;
`ifdef SPIKE_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  spike_train_gen dut (
    .clk           (clk),
    .rst           (rst),
    .boot_mode     (boot_mode),
    .event_in      (event_in),
    .high_cycles   (high_cycles),
    .refract_cycles(refract_cycles),
    .spike_out     (spike_out),
    .busy          (busy)
`ifdef SPIKE_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       b;
    logic [7:0] ev;
    logic [3:0] hc;
    logic [3:0] rc;
    logic [7:0] sp;
    logic [7:0] bz;
    int         dr;   // expected drop_count, -1 = not checked
  } vec_t;

  typedef struct {
    logic [7:0] sp;
    logic [7:0] bz;
    int         dr;
    int         idx;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(logic r, logic b, logic [7:0] ev, logic [3:0] hc,
                              logic [3:0] rc, logic [7:0] sp, logic [7:0] bz, int dr);
    vec_t v;
    v.r = r; v.b = b; v.ev = ev; v.hc = hc; v.rc = rc;
    v.sp = sp; v.bz = bz; v.dr = dr;
    tbl.push_back(v);
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (spike_out !== e.sp) begin
      n_bad++;
      $display("FAIL %s[%0d] spike_out: got %h expected %h", e.tag, e.idx, spike_out, e.sp);
    end
    n_cmp++;
    if (busy !== e.bz) begin
      n_bad++;
      $display("FAIL %s[%0d] busy: got %h expected %h", e.tag, e.idx, busy, e.bz);
    end
`ifdef SPIKE_DROP_CNT_EN
    if (e.dr >= 0) begin
      n_cmp++;
      if (int'(drop_count) != e.dr) begin
        n_bad++;
        $display("FAIL %s[%0d] drop_count: got %0d expected %0d", e.tag, e.idx, drop_count, e.dr);
      end
    end
`endif
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next
  // rising edge, then sample 1 time unit past that edge.
  task automatic step(input vec_t v, input int idx, input string tag);
    exp_t e;
    rst = v.r; boot_mode = v.b; event_in = v.ev;
    high_cycles = v.hc; refract_cycles = v.rc;
    e.sp = v.sp; e.bz = v.bz; e.dr = v.dr; e.idx = idx; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    vec_t v;
    int   acc;
    logic [7:0] prev_bz;

    rst = 1'b1; boot_mode = 1'b0; event_in = '0;
    high_cycles = '0; refract_cycles = '0;

    // Single event H=3 R=2 on ch0, with drops in HIGH and on last REFRACT cycle
    add(1,0,8'h00,3,2, 8'h00,8'h00, 0);
    add(0,0,8'h00,3,2, 8'h00,8'h00, 0);
    add(0,0,8'h01,3,2, 8'h01,8'h01, 0);
    add(0,0,8'h01,3,2, 8'h01,8'h01, 1);
    add(0,0,8'h00,3,2, 8'h01,8'h01,-1);
    add(0,0,8'h00,3,2, 8'h00,8'h01,-1);
    add(0,0,8'h00,3,2, 8'h00,8'h01,-1);
    add(0,0,8'h01,3,2, 8'h00,8'h00, 2);
    add(0,0,8'h00,3,2, 8'h00,8'h00, 2);
    // Zero config on ch7: 1-cycle spike, 1-cycle gap, back-to-back events dropped
    add(0,0,8'h80,0,0, 8'h80,8'h80, 2);
    add(0,0,8'h80,0,0, 8'h00,8'h80, 3);
    add(0,0,8'h80,0,0, 8'h00,8'h00, 4);
    add(0,0,8'h80,0,0, 8'h80,8'h80, 4);
    add(0,0,8'h00,0,0, 8'h00,8'h80,-1);
    add(0,0,8'h00,0,0, 8'h00,8'h00, 4);
    // Several channels at once, each with its own latched config
    add(0,0,8'h0F,2,1, 8'h0F,8'h0F, 4);
    add(0,0,8'h10,1,1, 8'h1F,8'h1F, 4);
    add(0,0,8'h00,1,1, 8'h00,8'h1F,-1);
    add(0,0,8'h00,1,1, 8'h00,8'h00, 4);
    // Mid-spike config change does not alter the spike in flight
    add(0,0,8'h02,5,1, 8'h02,8'h02, 4);
    add(0,0,8'h00,5,1, 8'h02,8'h02,-1);
    add(0,0,8'h00,1,9, 8'h02,8'h02,-1);
    add(0,0,8'h00,1,9, 8'h02,8'h02,-1);
    add(0,0,8'h00,1,9, 8'h02,8'h02,-1);
    add(0,0,8'h00,1,9, 8'h00,8'h02,-1);
    add(0,0,8'h00,1,9, 8'h00,8'h00, 4);
    // boot_mode freeze mid-spike with events present
    add(0,0,8'h04,4,1, 8'h04,8'h04, 4);
    add(0,0,8'h00,4,1, 8'h04,8'h04, 4);
    for (int i = 0; i < 10; i++) add(0,1,8'hFF,4,1, 8'h04,8'h04, 4);
    add(0,0,8'h00,4,1, 8'h04,8'h04, 4);
    add(0,0,8'h00,4,1, 8'h04,8'h04, 4);
    add(0,0,8'h00,4,1, 8'h00,8'h04, 4);
    add(0,0,8'h00,4,1, 8'h00,8'h00, 4);
    add(0,1,8'hFF,4,1, 8'h00,8'h00, 4);
    add(0,0,8'h00,4,1, 8'h00,8'h00, 4);
    // Reset (with boot_mode also high) truncates a spike; next event accepted
    add(0,0,8'h08,6,1, 8'h08,8'h08, 4);
    add(0,0,8'h00,6,1, 8'h08,8'h08, 4);
    add(1,1,8'h08,6,1, 8'h00,8'h00, 0);
    add(0,0,8'h08,2,1, 8'h08,8'h08, 0);
    add(0,0,8'h00,2,1, 8'h08,8'h08, 0);
    add(0,0,8'h00,2,1, 8'h00,8'h08, 0);
    add(0,0,8'h00,2,1, 8'h00,8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i, "table");

    // All channels flooded with events: period H+R+1 = 9, drop counter saturates
    v.r = 1; v.b = 0; v.ev = 8'h00; v.hc = 4; v.rc = 4;
    v.sp = 8'h00; v.bz = 8'h00; v.dr = 0;
    step(v, 0, "flood");
    acc = 0;
    prev_bz = 8'h00;
    for (int k = 1; k <= 100; k++) begin
      v.r = 0; v.ev = 8'hFF;
      v.sp = (((k - 1) % 9) < 4) ? 8'hFF : 8'h00;
      v.bz = ((k % 9) == 0) ? 8'h00 : 8'hFF;
      if (prev_bz == 8'hFF) acc = acc + 8;
      if (acc > 255) acc = 255;
      v.dr = acc;
      step(v, k, "flood");
      prev_bz = v.bz;
    end

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
